// File: rtl/nh_lcd_bus_timer_pkg.sv
// Shared types and timing defaults for the nh_lcd 8080-style bus timer.
package nh_lcd_bus_timer_pkg;

  localparam int CNT_W = 4;

  localparam int SETUP_CYCLES_DEF = 1;
  localparam int WR_PULSE_DEF     = 2;
  localparam int RD_PULSE_DEF     = 4;
  localparam int HOLD_CYCLES_DEF  = 1;
  localparam int RECOVERY_DEF     = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // Counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/nh_lcd_bus_timer.sv
// Turns single-cycle byte requests into timed 8080-style panel bus cycles.
// The io_data tri-state pad lives in the parent and is driven by o_data_oe.
module nh_lcd_bus_timer
  import nh_lcd_bus_timer_pkg::*;
#(
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int WR_PULSE     = WR_PULSE_DEF,
  parameter int RD_PULSE     = RD_PULSE_DEF,
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int RECOVERY     = RECOVERY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_stb,
  input  logic       i_rnw,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_busy,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic       o_cs_n,
  output logic       o_rs,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic [7:0] o_data_out,
  output logic       o_data_oe,
  input  logic [7:0] i_data_in
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rnw_q;

  // Gated by rst so nothing is offered upstream while the block is held in reset.
  assign o_ready = (state == ST_IDLE) && i_enable && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rnw_q      <= 1'b0;
      o_busy     <= 1'b0;
      o_rd_data  <= 8'h00;
      o_rd_valid <= 1'b0;
      o_cs_n     <= 1'b1;
      o_rs       <= 1'b0;
      o_wr_n     <= 1'b1;
      o_rd_n     <= 1'b1;
      o_data_out <= 8'h00;
      o_data_oe  <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_stb && o_ready) begin
            state      <= ST_SETUP;
            cnt        <= cnt_load(SETUP_CYCLES);
            rnw_q      <= i_rnw;
            o_rs       <= i_rs;
            o_data_out <= i_data;
            o_cs_n     <= 1'b0;
            o_data_oe  <= ~i_rnw;
            o_busy     <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state  <= ST_STROBE;
            cnt    <= rnw_q ? cnt_load(RD_PULSE) : cnt_load(WR_PULSE);
            o_wr_n <= rnw_q;
            o_rd_n <= ~rnw_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            state  <= ST_HOLD;
            cnt    <= cnt_load(HOLD_CYCLES);
            o_wr_n <= 1'b1;
            o_rd_n <= 1'b1;
            // Panel data is settled by the end of the strobe; no synchroniser.
            if (rnw_q) begin
              o_rd_data  <= i_data_in;
              o_rd_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state     <= ST_RECOVER;
            cnt       <= cnt_load(RECOVERY);
            o_cs_n    <= 1'b1;
            o_data_oe <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RECOVER: begin
          if (cnt == '0) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nh_lcd_bus_timer.sv
// Bench for nh_lcd_bus_timer: per-cycle comparison against a timeline model.
module tb_nh_lcd_bus_timer;

  localparam int S  = 1;
  localparam int WP = 2;
  localparam int RP = 4;
  localparam int H  = 1;
  localparam int R  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_stb = 1'b0;
  logic       i_rnw = 1'b0;
  logic       i_rs = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] i_data_in = 8'h00;
  logic       o_ready, o_busy, o_rd_valid, o_cs_n, o_rs, o_wr_n, o_rd_n, o_data_oe;
  logic [7:0] o_rd_data, o_data_out;

  nh_lcd_bus_timer #(
    .SETUP_CYCLES(S), .WR_PULSE(WP), .RD_PULSE(RP), .HOLD_CYCLES(H), .RECOVERY(R)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_stb(i_stb), .i_rnw(i_rnw),
    .i_rs(i_rs), .i_data(i_data), .o_ready(o_ready), .o_busy(o_busy),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_cs_n(o_cs_n), .o_rs(o_rs),
    .o_wr_n(o_wr_n), .o_rd_n(o_rd_n), .o_data_out(o_data_out), .o_data_oe(o_data_oe),
    .i_data_in(i_data_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a transaction is an accept cycle plus latched fields; outputs are
  // a pure function of the offset into the transaction.
  int         cyc = 0;
  int         k = 0;
  int         n_acc = 0;
  bit         has_txn = 0;
  logic       m_rnw = 0, m_rs = 0;
  logic [7:0] m_data = 0, m_rd_data = 0, m_samp = 0;
  logic [23:0] exp_vec, obs_vec;

  // Samples DUT and model at the negedge of the current cycle, then advances.
  task automatic cycle();
    int  d, p;
    bit  act, e_cs, e_str, e_wr, e_rd, e_oe, e_val, e_ready;
    @(negedge clk);
    if (!rst) begin
      has_txn = 0; m_rs = 0; m_data = 0; m_rd_data = 0;
    end
    d   = cyc - k;
    p   = m_rnw ? RP : WP;
    act = has_txn && (d < S + p + H + R + 1);
    if (act && m_rnw && d == S + p + 1) m_rd_data = m_samp;
    e_cs    = !(act && d <= S + p + H);
    e_str   = act && d > S && d <= S + p;
    e_wr    = !(e_str && !m_rnw);
    e_rd    = !(e_str && m_rnw);
    e_oe    = act && !m_rnw && d <= S + p + H;
    e_val   = act && m_rnw && d == S + p + 1;
    e_ready = rst && !act && i_enable;
    exp_vec = {e_ready, act, m_rd_data, e_val, e_cs, m_rs, e_wr, e_rd, m_data, e_oe};
    obs_vec = {o_ready, o_busy, o_rd_data, o_rd_valid, o_cs_n, o_rs, o_wr_n, o_rd_n,
               o_data_out, o_data_oe};
    if (act && m_rnw && d == S + p) m_samp = i_data_in;
    if (e_ready && i_stb) begin
      has_txn = 1; k = cyc; m_rnw = i_rnw; m_rs = i_rs; m_data = i_data;
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 0; i_enable = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if ({o_cs_n, o_wr_n, o_rd_n, o_data_oe, o_ready} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_pins got=%b exp=11100", {o_cs_n, o_wr_n, o_rd_n, o_data_oe, o_ready});
    end
    rst = 1;
    cycle();
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_write();
    int wr_low = 0;
    i_stb = 1; i_rnw = 0; i_rs = 1; i_data = 8'hA5;
    cycle();
    i_stb = 0; i_data = 8'h00;
    for (int i = 0; i < 7; i++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL write cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (obs_vec[10] == 1'b0) wr_low++;
    end
    checks++;
    if (wr_low !== WP) begin
      errors++;
      $display("FAIL write_pulse_len got=%0d exp=%0d", wr_low, WP);
    end
  endtask

  task automatic test_read();
    int vcount = 0;
    i_stb = 1; i_rnw = 1; i_rs = 0; i_data = 8'h00; i_data_in = 8'h3C;
    cycle();
    i_stb = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL read cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (obs_vec[13]) vcount++;
    end
    checks++;
    if (vcount !== 1 || o_rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL read_result valid=%0d data=%h exp=1/3c", vcount, o_rd_data);
    end
  endtask

  task automatic test_back_to_back();
    int base, pulses = 0, first;
    int starts[3];
    logic [7:0] vals[3];
    logic prev_wr = 1;
    base = n_acc;
    i_stb = 1; i_rnw = 0; i_rs = 0; i_data = 8'h01;
    for (int i = 0; i < 24; i++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (prev_wr && !obs_vec[10]) begin
        if (pulses < 3) begin
          starts[pulses] = cyc;
          vals[pulses] = obs_vec[8:1];
        end
        pulses++;
      end
      prev_wr = obs_vec[10];
      i_data = 8'(n_acc - base + 1);
      if (n_acc - base >= 3) i_stb = 0;
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=3", pulses);
    end else begin
      first = starts[0];
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (vals[j] !== 8'(j + 1) || starts[j] - first !== 6 * j) begin
          errors++;
          $display("FAIL b2b_order idx=%0d data=%h gap=%0d exp=%h/%0d",
                   j, vals[j], starts[j] - first, 8'(j + 1), 6 * j);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int base;
    base = n_acc;
    i_stb = 1; i_rnw = 0; i_rs = 1; i_data = 8'h55;
    cycle();
    i_stb = 0;
    for (int i = 0; i < 8; i++) begin
      i_stb = (i == 1 || i == 3); i_data = 8'hFF;
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL busy_ignore cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    i_stb = 0;
    checks++;
    if (o_data_out !== 8'h55 || n_acc - base !== 1) begin
      errors++;
      $display("FAIL busy_ignore_latch data=%h acc=%0d exp=55/1", o_data_out, n_acc - base);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    i_stb = 1; i_rnw = 0; i_rs = 1; i_data = 8'h77;
    cycle();
    i_stb = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (o_wr_n == 1'b0) found = 1;
      else cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_timeout wr_n never low");
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({o_wr_n, o_cs_n, o_data_oe, o_busy} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=1100", {o_wr_n, o_cs_n, o_data_oe, o_busy});
    end
    cycle();
    rst = 1; i_enable = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec || !obs_vec[23]) begin
        errors++;
        $display("FAIL reset_mid_release cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_enable_drop();
    i_enable = 1; i_stb = 1; i_rnw = 0; i_rs = 0; i_data = 8'hC3;
    cycle();
    i_stb = 0; i_enable = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL enable_drop cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    i_enable = 1;
    cycle();
    checks++;
    if (obs_vec !== exp_vec || !obs_vec[23]) begin
      errors++;
      $display("FAIL enable_return got=%h exp=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      i_stb     = ($urandom_range(0, 1) == 1);
      i_rnw     = ($urandom_range(0, 1) == 1);
      i_rs      = ($urandom_range(0, 1) == 1);
      i_data    = 8'($urandom);
      i_data_in = 8'($urandom);
      i_enable  = ($urandom_range(0, 9) != 0);
      rst       = ($urandom_range(0, 99) != 0);
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    rst = 1; i_stb = 0; i_enable = 1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
